// File: rtl/prime_search_pkg.sv
// Shared types and helpers for the prime search controller: FSM state
// encoding and the candidate stepping rule used by both RTL and models.
package prime_search_pkg;

    // Widest candidate the stepping helper can handle.
    localparam int CAND_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MR_RST  = 3'd1,
        MR_GO   = 3'd2,
        MR_WAIT = 3'd3,
        NEXT    = 3'd4,
        FIN     = 3'd5
    } state_t;

    // Step an odd, full-length candidate by 2. When the all-ones value is
    // reached it wraps to 2^(width-1)+1 so the result stays full-length and odd.
    function automatic logic [CAND_MAX_W-1:0] next_candidate(
        input logic [CAND_MAX_W-1:0] cand,
        input int                    width
    );
        logic [CAND_MAX_W-1:0] mask;
        logic [CAND_MAX_W-1:0] res;
        if (width >= CAND_MAX_W) begin
            mask = {CAND_MAX_W{1'b1}};
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        if ((cand & mask) == mask) begin
            res = (64'd1 << (width - 1)) | 64'd1;
        end else begin
            res = (cand + 64'd2) & mask;
        end
        return res;
    endfunction

endpackage

// File: rtl/prime_candidate_gen.sv
// Candidate register: loads an odd, full-length value from the seed and
// steps it by 2 (with wrap) on request. Its value drives mr_n directly.
module prime_candidate_gen
    import prime_search_pkg::*;
#(
    parameter int PRIME_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [PRIME_WIDTH-1:0] seed,
    input  logic                   step,
    output logic [PRIME_WIDTH-1:0] mr_n
);

    // MSB and LSB are forced high so every candidate is odd and full-length.
    localparam logic [PRIME_WIDTH-1:0] FORCE_MASK = {1'b1, {(PRIME_WIDTH-2){1'b0}}, 1'b1};

    logic [PRIME_WIDTH-1:0] cand_r;
    logic [PRIME_WIDTH-1:0] load_val_s;
    logic [PRIME_WIDTH-1:0] step_val_s;

    // Next-value candidates for the load and step paths.
    always_comb begin
        load_val_s = seed | FORCE_MASK;
        step_val_s = PRIME_WIDTH'(next_candidate(CAND_MAX_W'(cand_r), PRIME_WIDTH));
    end

    // Candidate register; load has priority over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= {PRIME_WIDTH{1'b0}};
        end else if (load) begin
            cand_r <= load_val_s;
        end else if (step) begin
            cand_r <= step_val_s;
        end else begin
            cand_r <= cand_r;
        end
    end

    assign mr_n = cand_r;

endmodule

// File: rtl/prime_search_ctrl.sv
// Sequencing controller for the Miller-Rabin primality unit: forms a
// candidate from the seed, tests it, steps by 2 on composite results and
// stops on a prime, on an exhausted try budget or on a watchdog expiry.
module prime_search_ctrl
    import prime_search_pkg::*;
#(
    parameter  int PRIME_WIDTH    = 16,
    parameter  int MAX_TRIES      = 256,
    parameter  int TIMEOUT_CYCLES = 65535,
    localparam int ATT_W          = $clog2(MAX_TRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PRIME_WIDTH-1:0] seed,
    input  logic [1:0]             sec_param,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [PRIME_WIDTH-1:0] prime,
    output logic [ATT_W-1:0]       attempts,
    output logic                   timeout_err,
    output logic                   mr_rst,
    output logic                   mr_enable,
    output logic [PRIME_WIDTH-1:0] mr_n,
    output logic [1:0]             mr_security_parameter,
    input  logic                   mr_done,
    input  logic                   mr_is_prime
);

    localparam int               WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_TRIES);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   found_r;
    logic [PRIME_WIDTH-1:0] prime_r;
    logic [ATT_W-1:0]       attempts_r;
    logic                   timeout_err_r;
    logic                   rst_pulse_r;
    logic                   mr_enable_r;
    logic [1:0]             sec_r;
    logic [WD_W-1:0]        wd_r;

    logic                   load_s;
    logic                   step_s;
    logic [PRIME_WIDTH-1:0] cand_s;

    assign load_s = (state_r == IDLE) && start;
    assign step_s = (state_r == NEXT);

    prime_candidate_gen #(
        .PRIME_WIDTH(PRIME_WIDTH)
    ) u_cand (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load_s),
        .seed (seed),
        .step (step_s),
        .mr_n (cand_s)
    );

    // Search FSM with attempt counter, watchdog and result registers.
    // Pulse outputs are raised on entry to their state so each lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            found_r       <= 1'b0;
            prime_r       <= {PRIME_WIDTH{1'b0}};
            attempts_r    <= {ATT_W{1'b0}};
            timeout_err_r <= 1'b0;
            rst_pulse_r   <= 1'b0;
            mr_enable_r   <= 1'b0;
            sec_r         <= 2'b00;
            wd_r          <= {WD_W{1'b0}};
        end else begin
            done_r      <= 1'b0;
            rst_pulse_r <= 1'b0;
            mr_enable_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sec_r         <= sec_param;
                        attempts_r    <= {ATT_W{1'b0}};
                        found_r       <= 1'b0;
                        timeout_err_r <= 1'b0;
                        busy_r        <= 1'b1;
                        rst_pulse_r   <= 1'b1;
                        state_r       <= MR_RST;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MR_RST: begin
                    mr_enable_r <= 1'b1;
                    state_r     <= MR_GO;
                end
                MR_GO: begin
                    attempts_r <= attempts_r + ATT_W'(1);
                    wd_r       <= {WD_W{1'b0}};
                    state_r    <= MR_WAIT;
                end
                MR_WAIT: begin
                    // A verdict takes priority over a coincident watchdog expiry.
                    if (mr_done) begin
                        if (mr_is_prime) begin
                            prime_r <= cand_s;
                            found_r <= 1'b1;
                            done_r  <= 1'b1;
                            state_r <= FIN;
                        end else if (attempts_r == ATT_MAX) begin
                            found_r <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= FIN;
                        end else begin
                            state_r <= NEXT;
                        end
                    end else if (wd_r == WD_LIMIT) begin
                        timeout_err_r <= 1'b1;
                        found_r       <= 1'b0;
                        done_r        <= 1'b1;
                        state_r       <= FIN;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                NEXT: begin
                    rst_pulse_r <= 1'b1;
                    state_r     <= MR_RST;
                end
                FIN: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy                  = busy_r;
    assign done                  = done_r;
    assign found                 = found_r;
    assign prime                 = prime_r;
    assign attempts              = attempts_r;
    assign timeout_err           = timeout_err_r;
    assign mr_enable             = mr_enable_r;
    assign mr_n                  = cand_s;
    assign mr_security_parameter = sec_r;
    // The primality unit is also held in reset while the controller is.
    assign mr_rst                = ~rst_n | rst_pulse_r;

endmodule

// File: tb/tb_prime_search_ctrl.sv
// Self-checking bench for prime_search_ctrl with a behavioural primality
// responder. Unit 0: MAX_TRIES=256, TIMEOUT_CYCLES=100. Unit 1: MAX_TRIES=1.
module tb_prime_search_ctrl;

    localparam int PW     = 8;
    localparam int MAXT_A = 256;
    localparam int TO_A   = 100;
    localparam int MAXT_B = 1;
    localparam int TO_B   = 1000;

    typedef struct {
        int unit;
        int found;
        int tmo;
        int prime;
        int att;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]        start_v;
    logic [1:0][7:0]   seed_v;
    logic [1:0][1:0]   sec_v;
    logic [1:0]        busy_v, done_v, found_v, tmo_v, mr_rst_v, mr_en_v;
    logic [1:0][7:0]   prime_v, mr_n_v;
    logic [1:0][8:0]   att_v;
    logic [1:0][1:0]   mr_sec_v;
    logic [1:0]        mr_done_v, mr_isp_v;

    for (genvar g = 0; g < 2; g++) begin : g_unit
        localparam int MT = (g == 0) ? MAXT_A : MAXT_B;
        localparam int TO = (g == 0) ? TO_A : TO_B;
        localparam int AW = $clog2(MT + 1);
        logic [AW-1:0] att_w;
        prime_search_ctrl #(
            .PRIME_WIDTH(PW), .MAX_TRIES(MT), .TIMEOUT_CYCLES(TO)
        ) dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[g]), .seed(seed_v[g]),
            .sec_param(sec_v[g]), .busy(busy_v[g]), .done(done_v[g]),
            .found(found_v[g]), .prime(prime_v[g]), .attempts(att_w),
            .timeout_err(tmo_v[g]), .mr_rst(mr_rst_v[g]), .mr_enable(mr_en_v[g]),
            .mr_n(mr_n_v[g]), .mr_security_parameter(mr_sec_v[g]),
            .mr_done(mr_done_v[g]), .mr_is_prime(mr_isp_v[g])
        );
        assign att_v[g] = 9'(att_w);
    end

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];

    int cyc = 0;
    int lat = 3;
    bit resp_on = 1'b1;
    bit inject  = 1'b0;
    int resp_cnt[2];
    bit verdict[2];
    int en_run[2];
    int rst_run[2];
    int en_cyc[2];
    int done_cyc[2];
    int n_done[2];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Independent reference: walk the candidate sequence and count tests.
    function automatic exp_t model(input int unit, input logic [7:0] seed, input int max_tries);
        exp_t       e;
        logic [7:0] c;
        bit         fin;
        c = seed;
        c[7] = 1'b1;
        c[0] = 1'b1;
        e.unit = unit; e.found = 0; e.tmo = 0; e.prime = 0; e.att = 0;
        fin = 1'b0;
        while (!fin) begin
            e.att++;
            if (is_prime(int'(c))) begin
                e.found = 1;
                e.prime = int'(c);
                fin = 1'b1;
            end else if (e.att == max_tries) begin
                fin = 1'b1;
            end else if (c == 8'hFF) begin
                c = 8'h81;
            end else begin
                c = c + 8'd2;
            end
        end
        return e;
    endfunction

    // Monitor and scoreboard on the falling edge, then the responder drives
    // mr_done/mr_is_prime for the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        for (int u = 0; u < 2; u++) begin
            mr_done_v[u] = 1'b0;
            mr_isp_v[u]  = 1'b0;
            if (!rst_n) begin
                resp_cnt[u] = 0;
                en_run[u]   = 0;
                rst_run[u]  = 0;
            end else begin
                if (mr_en_v[u]) begin
                    en_run[u]++;
                    en_cyc[u] = cyc;
                    check("mr_n_odd", int'(mr_n_v[u][0]), 1);
                    check("mr_n_msb", int'(mr_n_v[u][7]), 1);
                end else if (en_run[u] != 0) begin
                    check("mr_enable_width", en_run[u], 1);
                    en_run[u] = 0;
                end
                if (mr_rst_v[u]) begin
                    rst_run[u]++;
                end else if (rst_run[u] != 0) begin
                    check("mr_rst_width", rst_run[u], 1);
                    rst_run[u] = 0;
                end
                if (done_v[u]) begin
                    done_cyc[u] = cyc;
                    n_done[u]++;
                    if (sb.size() == 0) begin
                        check("sb_underflow", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check("unit", u, e.unit);
                        check("found", int'(found_v[u]), e.found);
                        check("timeout_err", int'(tmo_v[u]), e.tmo);
                        check("attempts", int'(att_v[u]), e.att);
                        if (e.found != 0) check("prime", int'(prime_v[u]), e.prime);
                        check("busy_at_done", int'(busy_v[u]), 1);
                    end
                end
                if (inject && mr_rst_v[u]) begin
                    mr_done_v[u] = 1'b1;
                    mr_isp_v[u]  = 1'b1;
                end
                if (mr_en_v[u] && resp_on) begin
                    resp_cnt[u] = lat;
                    verdict[u]  = is_prime(int'(mr_n_v[u]));
                end else if (resp_cnt[u] > 0) begin
                    resp_cnt[u]--;
                    if (resp_cnt[u] == 0) begin
                        mr_done_v[u] = 1'b1;
                        mr_isp_v[u]  = verdict[u];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_search(input int u, input logic [7:0] seed, input logic [1:0] sec,
                              input exp_t e, input bit spam);
        int d0;
        int cnt;
        start_v[u] = 1'b1;
        seed_v[u]  = seed;
        sec_v[u]   = sec;
        sb.push_back(e);
        d0 = n_done[u];
        tick();
        start_v[u] = 1'b0;
        check("busy_after_start", int'(busy_v[u]), 1);
        check("mr_rst_in_mr_rst", int'(mr_rst_v[u]), 1);
        check("mr_n_first", int'(mr_n_v[u]), int'(seed | 8'h81));
        check("sec_latched", int'(mr_sec_v[u]), int'(sec));
        if (spam) begin
            seed_v[u] = 8'hFE;
            sec_v[u]  = ~sec;
        end
        cnt = 0;
        while (n_done[u] == d0 && cnt < 3000) begin
            if (spam) start_v[u] = busy_v[u];
            tick();
            cnt++;
        end
        tick();
        start_v[u] = 1'b0;
        check("done_count", n_done[u] - d0, 1);
        check("busy_dropped", int'(busy_v[u]), 0);
        tick();
        check("single_done", n_done[u] - d0, 1);
        check("stays_idle", int'(busy_v[u]), 0);
        check("sec_hold", int'(mr_sec_v[u]), int'(sec));
    endtask

    task automatic check_reset_outputs(input int u);
        check("rst_mr_rst", int'(mr_rst_v[u]), 1);
        check("rst_busy", int'(busy_v[u]), 0);
        check("rst_done", int'(done_v[u]), 0);
        check("rst_found", int'(found_v[u]), 0);
        check("rst_tmo", int'(tmo_v[u]), 0);
        check("rst_mr_enable", int'(mr_en_v[u]), 0);
        check("rst_prime", int'(prime_v[u]), 0);
        check("rst_attempts", int'(att_v[u]), 0);
        check("rst_mr_n", int'(mr_n_v[u]), 0);
        check("rst_sec", int'(mr_sec_v[u]), 0);
    endtask

    initial begin
        exp_t e;
        int   d0;
        rst_n   = 1'b0;
        start_v = 2'b00;
        seed_v  = '0;
        sec_v   = '0;
        for (int u = 0; u < 2; u++) begin
            resp_cnt[u] = 0; en_run[u] = 0; rst_run[u] = 0;
            en_cyc[u] = 0; done_cyc[u] = 0; n_done[u] = 0; verdict[u] = 1'b0;
        end
        tick(); tick();
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst_n = 1'b1;
        tick();
        check("mr_rst_release", int'(mr_rst_v[0]), 0);

        // Seed 0x00: 0x81 composite, 0x83 prime.
        run_search(0, 8'h00, 2'd2, model(0, 8'h00, MAXT_A), 1'b0);
        // Seed 0x10, fast responder: 0x91, 0x93 composite, 0x95 prime.
        lat = 1;
        run_search(0, 8'h10, 2'd1, model(0, 8'h10, MAXT_A), 1'b0);
        // Seed 0xFE: 0xFF composite, wraps to 0x81, then 0x83.
        lat = 5;
        run_search(0, 8'hFE, 2'd3, model(0, 8'hFE, MAXT_A), 1'b0);
        // Single-try budget: composite and prime first candidates.
        lat = 3;
        run_search(1, 8'h00, 2'd2, model(1, 8'h00, MAXT_B), 1'b0);
        run_search(1, 8'h02, 2'd0, model(1, 8'h02, MAXT_B), 1'b0);

        // Watchdog: no verdict ever; done arrives TIMEOUT_CYCLES cycles after
        // the enable pulse has ended.
        resp_on = 1'b0;
        e.unit = 0; e.found = 0; e.tmo = 1; e.prime = 0; e.att = 1;
        run_search(0, 8'h20, 2'd2, e, 1'b0);
        check("wd_latency", done_cyc[0] - en_cyc[0], TO_A + 1);
        resp_on = 1'b1;

        // Start spam while busy and a prime verdict injected during MR_RST.
        inject = 1'b1;
        run_search(0, 8'h00, 2'd2, model(0, 8'h00, MAXT_A), 1'b1);
        inject = 1'b0;

        // Asynchronous reset in the middle of a verdict wait.
        lat = 40;
        start_v[0] = 1'b1;
        seed_v[0]  = 8'h00;
        sec_v[0]   = 2'd2;
        d0 = n_done[0];
        tick();
        start_v[0] = 1'b0;
        repeat (5) tick();
        check("pre_rst_busy", int'(busy_v[0]), 1);
        check("pre_rst_mr_n", int'(mr_n_v[0]), 8'h81);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(0);
        repeat (3) tick();
        check("no_done_on_reset", n_done[0] - d0, 0);
        check("sb_empty_after_reset", sb.size(), 0);
        rst_n = 1'b1;
        tick();
        lat = 3;
        run_search(0, 8'h00, 2'd2, model(0, 8'h00, MAXT_A), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/prime_search_ctrl.md
Name: prime_search_ctrl

Overview:
Sequencing controller for the Miller-Rabin primality datapath in the RSA key-generation path. From a seed it forms an odd, full-length candidate and runs the primality unit on it. On a composite result it steps the candidate by 2 and retries, until a prime is found, the try budget runs out, or a per-test watchdog expires. The found prime feeds the P/Q registers of the key generator.

Parameters:
PRIME_WIDTH, 16, candidate width (equals WORD_WIDTH/2 of the primality datapath)
MAX_TRIES, 256, maximum candidates tested per search (>=1)
TIMEOUT_CYCLES, 65535, watchdog limit per primality test, in cycles
ATT_W, $clog2(MAX_TRIES+1), attempts counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin a search; sampled in IDLE only
seed  in  PRIME_WIDTH  search start value
sec_param  in  2  Miller-Rabin rounds; passed through and latched at start
busy  out  1  high from the cycle after accepted start until FIN exits
done  out  1  one-cycle completion pulse
found  out  1  search ended on a prime; valid from done until next accepted start
prime  out  PRIME_WIDTH  found prime; valid while found=1
attempts  out  ATT_W  candidates tested in the last or current search
timeout_err  out  1  watchdog expired; valid from done until next start
mr_rst  out  1  active-high reset to primality unit
mr_enable  out  1  one-cycle start pulse to primality unit
mr_n  out  PRIME_WIDTH  candidate; stable from MR_RST through MR_WAIT
mr_security_parameter  out  2  latched sec_param
mr_done  in  1  primality unit completion pulse
mr_is_prime  in  1  verdict; sampled only when mr_done=1

Behaviour:
- Reset (rst_n low): state=IDLE. busy, done, found, timeout_err, mr_enable all 0. prime, attempts, mr_n, mr_security_parameter all 0. mr_rst=1 combinationally while rst_n low (mr_rst = ~rst_n | rst_pulse). Reset mid-search abandons the search with no done pulse.
- All outputs except mr_rst are registered.
- IDLE: start=1 -> cand={1'b1, seed[PRIME_WIDTH-2:1], 1'b1} (MSB and LSB forced). Latch sec_param. attempts=0. found=0, timeout_err=0. -> MR_RST.
- MR_RST: mr_rst=1 for exactly 1 cycle; mr_n=cand. -> MR_GO.
- MR_GO: mr_enable=1 for exactly 1 cycle; attempts+=1; watchdog counter wd=0. -> MR_WAIT.
- MR_WAIT: wd+=1 each cycle.
  - mr_done=1 and mr_is_prime=1 -> prime=cand, found=1, -> FIN.
  - mr_done=1, composite, attempts==MAX_TRIES -> found=0, -> FIN.
  - mr_done=1, composite otherwise -> NEXT.
  - No mr_done and wd==TIMEOUT_CYCLES-1 -> timeout_err=1, found=0, -> FIN.
  - If mr_done and the timeout limit coincide, mr_done wins.
  - mr_done outside MR_WAIT is ignored.
- NEXT: if cand == all-ones, cand = 2^(PRIME_WIDTH-1)+1 (wrap, stays full-length and odd); else cand = cand+2. -> MR_RST.
- FIN: done=1 for 1 cycle; busy drops with FIN exit. -> IDLE.
- start while busy is ignored. start in the same cycle that FIN exits is ignored; accepted from IDLE next cycle.
- Per-candidate overhead: 3 cycles (NEXT, MR_RST, MR_GO) plus primality latency.
- attempts saturates at MAX_TRIES by construction. It holds its final value in IDLE.

Decomposition:
- Package prime_search_pkg: state_t enum (IDLE, MR_RST, MR_GO, MR_WAIT, NEXT, FIN) and function next_candidate(cand) implementing the step-by-2-with-wrap rule, shared with the key-generator testbench model.
- One sub-module, prime_candidate_gen: holds cand, with load(seed) and step inputs, and outputs mr_n. The FSM, counters and watchdog stay in prime_search_ctrl.

Test Plan:
(Behavioural primality responder with configurable latency, plus one integration run against the real datapath. PRIME_WIDTH=8.)
1. seed=0x00, sec_param=2, responder exact verdicts -> tests 0x81 (composite) then 0x83 (prime); done pulse with found=1, prime=0x83, attempts=2, timeout_err=0.
2. seed=0xFE -> candidates 0xFF, wrap to 0x81, then 0x83; prime=0x83, attempts=3; mr_n never even and never <0x80.
3. MAX_TRIES=1, seed=0x00 -> single test of 0x81; done with found=0, attempts=1.
4. TIMEOUT_CYCLES=100, responder never asserts mr_done -> timeout_err=1, found=0, done exactly 100 cycles after the mr_enable pulse.
5. start pulsed repeatedly while busy, and mr_done injected in MR_RST -> both ignored, result identical to scenario 1; mr_enable exactly 1 cycle and mr_rst exactly 1 cycle per candidate.
6. rst_n deasserted mid-MR_WAIT, async -> mr_rst high immediately and all outputs 0 with no done pulse; a new start afterwards reproduces scenario 1.
